// File: rtl/etaii_pkg.sv
// Shared types and helpers for the segmented ETAII-modified adder.
// Segment geometry lives here so the top and the segment cell agree on it.
package etaii_pkg;

    localparam int SEG_W    = 4;
    localparam int N_SEG    = 8;
    localparam int ACC_SEGS = 3;

    typedef logic [SEG_W-1:0] seg_t;

    // Group generate: the carry a segment produces on its own, with carry-in forced to 0.
    function automatic logic seg_gen(input seg_t a, input seg_t b);
        logic [SEG_W:0] groupSum;
        groupSum = {1'b0, a} + {1'b0, b};
        return groupSum[SEG_W];
    endfunction

endpackage

// File: rtl/etaii_seg4.sv
// One 4-bit segment of the adder: an exact segment sum, its true carry-out,
// and the carry-in-independent generate used to feed the next lower-region segment.
module etaii_seg4
    import etaii_pkg::*;
(
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin,
    output logic [SEG_W-1:0] sum,
    output logic             gen,
    output logic             cout
);

    logic [SEG_W:0] fullSum;

    assign fullSum = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, cin};
    assign sum     = fullSum[SEG_W-1:0];
    assign cout    = fullSum[SEG_W];
    assign gen     = seg_gen(seg_t'(a), seg_t'(b));

endmodule

// File: rtl/etaiim32_adder.sv
// 32-bit approximate error-tolerant adder with a registered output.
// Lower segments take their carry from the neighbour's generate only; the top segments ripple exactly.
module etaiim32_adder
    import etaii_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int SEG_W    = etaii_pkg::SEG_W,
    parameter int ACC_SEGS = etaii_pkg::ACC_SEGS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] S
);

    localparam int NSEG     = WIDTH / SEG_W;
    localparam int LOW_SEGS = NSEG - ACC_SEGS;

    logic [NSEG-1:0]  segGen;
    logic [NSEG-1:0]  segCout;
    logic [NSEG-1:0]  carryIn;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;

    genvar k;
    generate
        for (k = 0; k < NSEG; k++) begin : g_seg
            // The first accurate segment still takes its carry from the last approximate generate.
            if (k == 0) begin : g_first
                assign carryIn[k] = 1'b0;
            end else if (k <= LOW_SEGS) begin : g_approx
                assign carryIn[k] = segGen[k-1];
            end else begin : g_exact
                assign carryIn[k] = segCout[k-1];
            end

            etaii_seg4 u_seg (
                .a    (A[SEG_W*k +: SEG_W]),
                .b    (B[SEG_W*k +: SEG_W]),
                .cin  (carryIn[k]),
                .sum  (sum_d[SEG_W*k +: SEG_W]),
                .gen  (segGen[k]),
                .cout (segCout[k])
            );
        end
    endgenerate

    // Lower true carries are discarded by design, upper generates are not needed, and the MSB carry wraps.
    logic unusedCarries;
    assign unusedCarries = ^{segGen[NSEG-1:LOW_SEGS], segCout[LOW_SEGS-1:0], segCout[NSEG-1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign S = sum_q;

endmodule

// File: tb/tb_etaiim32_adder.sv
// Directed and random checks of the registered ETAII-modified adder.
// Expected values are hand-computed constants or a segment-equation reference model.
module tb_etaiim32_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] S;

    int checkCount = 0;
    int passCount  = 0;

    etaiim32_adder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .S     (S)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drive one vector away from the edge, then let the output register capture it.
    task automatic applyStimulus(input logic resetN, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        rst_n = resetN;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
    endtask

    // Reference built straight from the segment equations: lower carries come from generates only.
    function automatic logic [31:0] refSum(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] s;
        logic        c;
        logic [4:0]  t;
        logic [11:0] upper;
        c = 1'b0;
        for (int k = 0; k < 5; k++) begin
            t = {1'b0, a[4*k +: 4]} + {1'b0, b[4*k +: 4]} + {4'b0, c};
            s[4*k +: 4] = t[3:0];
            t = {1'b0, a[4*k +: 4]} + {1'b0, b[4*k +: 4]};
            c = t[4];
        end
        upper = a[31:20] + b[31:20] + {11'b0, c};
        s[31:20] = upper;
        return s;
    endfunction

    logic [31:0] vecA [8] = '{32'h00000001, 32'h12345678, 32'h0000000F, 32'hF0000000,
                              32'h00088888, 32'h00000F0F, 32'hFFFFFFFF, 32'h0FF00000};
    logic [31:0] vecB [8] = '{32'h00000001, 32'h11111111, 32'h00000001, 32'h10000000,
                              32'h00088888, 32'h00000001, 32'h00000001, 32'h00100000};
    logic [31:0] vecS [8] = '{32'h00000002, 32'h23456789, 32'h00000010, 32'h00000000,
                              32'h00111110, 32'h00000F10, 32'hFFFFFF00, 32'h10000000};

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] diff;

        rst_n = 1'b0;
        A     = '0;
        B     = '0;

        applyStimulus(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        checkOutput("reset", S, 32'h0);
        applyStimulus(1'b1, 32'd3, 32'd2);
        checkOutput("3+2", S, 32'd5);
        applyStimulus(1'b1, 32'd4, 32'd3);
        checkOutput("4+3", S, 32'd7);

        applyStimulus(1'b1, 32'hD, 32'hA);
        checkOutput("gen0_feeds_seg1", S, 32'h17);

        applyStimulus(1'b1, 32'hFF, 32'h1);
        checkOutput("lost_carry_seg1", S, 32'h000);
        applyStimulus(1'b1, 32'hFFFFFFFF, 32'h1);
        checkOutput("lost_carry_all_ones", S, 32'hFFFFFF00);

        applyStimulus(1'b1, 32'h0FF00000, 32'h00100000);
        checkOutput("upper_ripple", S, 32'h10000000);
        applyStimulus(1'b1, 32'h000F0000, 32'h00010000);
        checkOutput("gen4_into_chain", S, 32'h00100000);

        // Back-to-back: a fresh vector every cycle, each checked on the cycle after it was applied.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, vecA[i], vecB[i]);
            checkOutput($sformatf("stream%0d", i), S, vecS[i]);
        end

        applyStimulus(1'b0, 32'h12345678, 32'h11111111);
        checkOutput("midstream_reset", S, 32'h0);
        applyStimulus(1'b1, 32'h12345678, 32'h11111111);
        checkOutput("after_reset", S, 32'h23456789);

        for (int i = 0; i < 10000; i++) begin
            a = $urandom;
            if (i % 2 == 0) begin
                b = $urandom;
            end else begin
                b = ~a + 32'($urandom_range(0, 255));
            end
            applyStimulus(1'b1, a, b);
            checkOutput("random_model", S, refSum(a, b));
            diff = (a + b) - S;
            checkOutput("random_error_shape", diff & ~32'h00111110, 32'h0);
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
